// File: rtl/draw_dashed_line.sv
// draw_dashed_line: streams the pixels of a vertical dashed line, one pixel per accepted handshake
//   clock      in   sole clock, rising edge
//   resetn     in   synchronous active-low reset
//   start      in   request one pass (sampled in IDLE only)
//   erase      in   latched with start; forces colour 0
//   colourIn   in   latched with start
//   plotReady  in   downstream accepts the current pixel
//   xOut/yOut  out  current pixel column/row
//   colourOut  out  current pixel colour
//   plot       out  pixel valid
//   busy       out  high while drawing
//   done       out  pass complete (level, cleared by next start or reset)
module draw_dashed_line #(
    parameter int X_POS    = 79,
    parameter int Y_START  = 0,
    parameter int Y_END    = 119,
    parameter int DASH_LEN = 2,
    parameter int GAP_LEN  = 2,
    parameter int LINE_W   = 1,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                erase,
    input  logic [COLOUR_W-1:0] colourIn,
    input  logic                plotReady,
    output logic [7:0]          xOut,
    output logic [6:0]          yOut,
    output logic [COLOUR_W-1:0] colourOut,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam int CW = DASH_LEN > 1 ? $clog2(DASH_LEN) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(DASH_LEN - 1);
    localparam logic [7:0]    X_FIRST = 8'(X_POS);
    localparam logic [7:0]    X_LAST  = 8'(X_POS + LINE_W - 1);
    localparam logic [7:0]    Y_FIRST = 8'(Y_START);
    localparam logic [7:0]    Y_LAST  = 8'(Y_END);
    localparam logic [7:0]    GAP     = 8'(GAP_LEN);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t              r_state, w_state_n;
    logic [7:0]          r_x, w_x_n, r_y, w_y_n, w_row_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic [COLOUR_W-1:0] r_col, w_col_n;
    logic                r_done, w_done_n;
    logic                w_last_col, w_last_dash;

    assign w_last_col  = r_x == X_LAST;
    assign w_last_dash = r_cnt == C_LAST;
    // End of a dash skips the whole gap in one step, so gap rows cost no cycles.
    assign w_row_n     = w_last_dash ? r_y + 8'd1 + GAP : r_y + 8'd1;

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_cnt_n   = r_cnt;
        w_col_n   = r_col;
        w_done_n  = r_done;
        if (r_state == IDLE) begin
            if (start) begin
                w_state_n = DRAW;
                w_x_n     = X_FIRST;
                w_y_n     = Y_FIRST;
                w_cnt_n   = '0;
                w_col_n   = erase ? '0 : colourIn;
                w_done_n  = 1'b0;
            end
        end else if (plotReady) begin
            w_x_n = w_last_col ? X_FIRST : r_x + 8'd1;
            if (w_last_col) begin
                if (w_row_n > Y_LAST) begin
                    w_state_n = IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_y_n   = w_row_n;
                    w_cnt_n = w_last_dash ? '0 : r_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cnt  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
        end else begin
            r_x    <= w_x_n;
            r_y    <= w_y_n;
            r_cnt  <= w_cnt_n;
            r_col  <= w_col_n;
            r_done <= w_done_n;
        end
    end

    assign xOut      = r_x;
    assign yOut      = r_y[6:0];
    assign colourOut = r_col;
    assign plot      = r_state == DRAW;
    assign busy      = r_state == DRAW;
    assign done      = r_done;
endmodule

// File: tb/tb_draw_dashed_line.sv
// tb_draw_dashed_line: directed checks of draw_dashed_line with three parameter sets
module tb_draw_dashed_line;
    logic       clock = 0, resetn = 0, start = 0, erase = 0, plotReady = 1;
    logic [2:0] colourIn = 0;
    logic [7:0] xo [3];
    logic [6:0] yo [3];
    logic [2:0] co [3];
    logic       po [3], bo [3], dn [3];
    int         checks = 0, failures = 0, sel = 0;

    always #5 clock = ~clock;

    draw_dashed_line u0 (
        .clock(clock), .resetn(resetn), .start(start), .erase(erase), .colourIn(colourIn),
        .plotReady(plotReady), .xOut(xo[0]), .yOut(yo[0]), .colourOut(co[0]),
        .plot(po[0]), .busy(bo[0]), .done(dn[0]));
    draw_dashed_line #(.LINE_W(2), .GAP_LEN(0), .Y_START(10), .Y_END(13)) u1 (
        .clock(clock), .resetn(resetn), .start(start), .erase(erase), .colourIn(colourIn),
        .plotReady(plotReady), .xOut(xo[1]), .yOut(yo[1]), .colourOut(co[1]),
        .plot(po[1]), .busy(bo[1]), .done(dn[1]));
    draw_dashed_line #(.DASH_LEN(3), .GAP_LEN(2), .Y_START(0), .Y_END(6)) u2 (
        .clock(clock), .resetn(resetn), .start(start), .erase(erase), .colourIn(colourIn),
        .plotReady(plotReady), .xOut(xo[2]), .yOut(yo[2]), .colourOut(co[2]),
        .plot(po[2]), .busy(bo[2]), .done(dn[2]));

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One pass on instance sel; start stays high for 'hold' cycles, tog alternates plotReady 1/0.
    task automatic run_pass(input string tag, input int ys, input int ye, input int d, input int g,
                            input int w, input int col, input bit tog, input int hold);
        int ex[$], ey[$], gx[$], gy[$];
        int bad = 0, cyc = 0, hx = 0, hy = 0;
        bit stalled;
        for (int y = ys; y <= ye; y++)
            if (((y - ys) % (d + g)) < d)
                for (int k = 0; k < w; k++) begin
                    ex.push_back(79 + k);
                    ey.push_back(y);
                end
        start = 1;
        tick();
        check({tag, "_busy"}, int'(bo[sel]), 1);
        check({tag, "_done_clr"}, int'(dn[sel]), 0);
        while (po[sel] && cyc < 400) begin
            start     = (cyc + 1 < hold);
            plotReady = tog ? (cyc % 2 == 0) : 1'b1;
            if (co[sel] !== 3'(col)) bad++;
            if (plotReady) begin
                gx.push_back(int'(xo[sel]));
                gy.push_back(int'(yo[sel]));
            end else begin
                hx = int'(xo[sel]);
                hy = int'(yo[sel]);
            end
            stalled = !plotReady;
            tick();
            cyc++;
            if (stalled && (int'(xo[sel]) != hx || int'(yo[sel]) != hy || !po[sel])) bad++;
        end
        start     = 0;
        plotReady = 1;
        check({tag, "_no_timeout"}, int'(cyc < 400), 1);
        check({tag, "_count"}, gx.size(), ex.size());
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) bad++;
        check({tag, "_seq_errs"}, bad, 0);
        check({tag, "_cycles"}, cyc, tog ? 2 * ex.size() - 1 : ex.size());
        check({tag, "_done"}, int'(dn[sel]), 1);
        check({tag, "_idle"}, int'(bo[sel] | po[sel]), 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_out", i), int'(xo[i]) + int'(yo[i]) + int'(co[i]), 0);
            check($sformatf("rst%0d_flags", i), int'(po[i]) + int'(bo[i]) + int'(dn[i]), 0);
        end
        resetn = 1;
        tick();
        check("idle_no_start", int'(po[0]), 0);

        sel = 0; colourIn = 3'b111; erase = 0;
        run_pass("dflt", 0, 119, 2, 2, 1, 7, 0, 1);
        run_pass("stall", 0, 119, 2, 2, 1, 7, 1, 1);
        run_pass("hold", 0, 119, 2, 2, 1, 7, 0, 6);
        run_pass("replay", 0, 119, 2, 2, 1, 7, 0, 1);

        start = 1;
        tick();
        start = 0;
        n = 0;
        while (yo[0] != 7'd40 && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach40", int'(n < 200), 1);
        resetn = 0;
        tick();
        resetn = 1;
        check("rst_mid_plot", int'(po[0]), 0);
        check("rst_mid_busy", int'(bo[0]), 0);
        check("rst_mid_done", int'(dn[0]), 0);
        check("rst_mid_xy", int'(xo[0]) + int'(yo[0]), 0);
        start = 1;
        tick();
        start = 0;
        check("restart_y", int'(yo[0]), 0);
        check("restart_x", int'(xo[0]), 79);
        check("restart_plot", int'(po[0]), 1);
        n = 0;
        while (po[0] && n < 200) begin
            tick();
            n++;
        end
        check("restart_finish", int'(dn[0]), 1);

        sel = 1; erase = 1; colourIn = 3'b101;
        run_pass("wide_erase", 10, 13, 2, 0, 2, 0, 0, 1);
        sel = 2; erase = 0; colourIn = 3'b011;
        run_pass("trunc", 0, 6, 3, 2, 1, 3, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
